display_shift_driver: RTL and testbench

//  Parametrised serial driver for an external shift-register 7-segment display.

---
 rtl/display_shift_driver_if.sv | 49 ++++
 rtl/display_shift_driver.sv | 217 +++++++++++++++++++++
 tb/tb_display_shift_driver.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_shift_driver_if.sv
// -----------------------------------------------------------------------------
// display_shift_driver_if
//  Bundles the load handshake and the serial display pins of
//  display_shift_driver into one interface.
//
//  Signals:
//   bcd_in      4*NUM_DIGITS  digit nibbles, [3:0] = least significant digit
//   dp_in       NUM_DIGITS    decimal point per digit, bit i -> digit i
//   load        1             request to send a frame
//   ready       1             driver idle and able to accept a frame
//   data_out    1             serial segment data
//   clk_logica  1             generated shift clock (rising edge samples data)
//   data_ready  1             latch strobe after the last bit of a frame
//
//  Modports:
//   master  result logic side: drives bcd_in/dp_in/load, observes the rest
//   slave   driver side: observes bcd_in/dp_in/load, drives the rest
// -----------------------------------------------------------------------------
interface display_shift_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    ready;
    logic                    data_out;
    logic                    clk_logica;
    logic                    data_ready;

    modport master (
        output bcd_in,
        output dp_in,
        output load,
        input  ready,
        input  data_out,
        input  clk_logica,
        input  data_ready
    );

    modport slave (
        input  bcd_in,
        input  dp_in,
        input  load,
        output ready,
        output data_out,
        output clk_logica,
        output data_ready
    );
endinterface

// File: rtl/display_shift_driver.sv
// -----------------------------------------------------------------------------
// display_shift_driver
//  Serial driver for a chain of shift-register 7-segment displays. On an
//  accepted load the digit nibbles and decimal points are converted into one
//  8-bit segment word per digit ({dp,g,f,e,d,c,b,a}) and the whole frame is
//  shifted out, most significant digit first and dp bit first within each
//  word, with a generated shift clock. A latch strobe follows the last bit.
//
//  Parameters:
//   NUM_DIGITS  digits in the chain (>=1), frame is 8*NUM_DIGITS bits
//   CLK_DIV     clk cycles per shift-clock half-period (>=1)
//   ACTIVE_LOW  1 inverts all 8 segment bits for common-anode parts
//
//  Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   display_shift_driver_if.slave (bcd_in, dp_in, load, ready,
//         data_out, clk_logica, data_ready)
//
//  Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank zero digits above the highest nonzero digit
//                          (digit 0 never blanked, dp still shown). Frame
//                          length and timing do not change.
// -----------------------------------------------------------------------------
module display_shift_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    display_shift_driver_if.slave bus
);

    localparam int FRAME_BITS = 8 * NUM_DIGITS;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    phase;
    logic [FRAME_BITS-1:0]   frame;
    logic [FRAME_BITS-1:0]   frame_new;
    logic                    accept;
    logic                    div_end;
    logic                    ready_c;
    logic                    data_out_c;
    logic                    clk_logica_c;
    logic                    data_ready_c;

    // Hex glyph table, active-high, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
        endcase
    endfunction

    // Digit i lands in frame[8*i +: 8], so the top of the frame holds the most
    // significant digit and shifting out from the MSB gives MSD-first, dp-first.
    // Blanking walks from the top digit down and stops at the first nonzero one.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [4*NUM_DIGITS-1:0] bcd,
        input logic [NUM_DIGITS-1:0]   dp
    );
        logic [FRAME_BITS-1:0] f;
        logic [7:0]            word;
        logic [3:0]            nib;
`ifdef LEADING_ZERO_BLANK_EN
        logic                  leading;
        leading = 1'b1;
`endif
        f = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib  = bcd[4*i +: 4];
            word = {dp[i], glyph(nib)};
`ifdef LEADING_ZERO_BLANK_EN
            if (nib != 4'h0) begin
                leading = 1'b0;
            end
            if (leading && (i != 0)) begin
                word[6:0] = 7'h00;
            end
`endif
            if (ACTIVE_LOW) begin
                word = ~word;
            end
            f[8*i +: 8] = word;
        end
        return f;
    endfunction

    assign frame_new = build_frame(bus.bcd_in, bus.dp_in);
    assign accept    = (state == IDLE) && bus.load;
    assign div_end   = (div_cnt == DIV_LAST);

    // State register; reset drops straight back to IDLE from any state, so a
    // partial frame never reaches LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and Moore outputs. data_out only follows the frame in SHIFT,
    // and the shift clock is the phase bit: low half first, then high half.
    always_comb begin
        state_next   = state;
        ready_c      = 1'b0;
        data_out_c   = 1'b0;
        clk_logica_c = 1'b0;
        data_ready_c = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.load) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                data_out_c   = frame[FRAME_BITS-1];
                clk_logica_c = phase;
                if (div_end && phase && (bit_cnt == BIT_LAST)) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                data_ready_c = 1'b1;
                if (div_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: the frame is captured at accept so later input changes are
    // ignored. div_cnt times each half-period; the frame shifts and bit_cnt
    // advances only at the end of a high half, so data is held while the
    // external register samples on the rising shift-clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            frame   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame   <= frame_new;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (phase) begin
                            frame   <= frame << 1;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (div_end) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    div_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ready      = ready_c;
    assign bus.data_out   = data_out_c;
    assign bus.clk_logica = clk_logica_c;
    assign bus.data_ready = data_ready_c;

endmodule

// File: tb/tb_display_shift_driver.sv
// -----------------------------------------------------------------------------
// tb_display_shift_driver
//  Two driver instances: a 4-digit CLK_DIV=2 active-high chain for the
//  handshake, timing and reset scenarios, and a 6-digit CLK_DIV=1 active-low
//  chain run with load held high. Expected segment bytes are queued when a
//  frame is requested and compared as the serial stream is reassembled.
// -----------------------------------------------------------------------------
module tb_display_shift_driver;

    localparam int ND_A = 4;
    localparam int CD_A = 2;
    localparam bit AL_A = 1'b0;
    localparam int ND_B = 6;
    localparam int CD_B = 1;
    localparam bit AL_B = 1'b1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    display_shift_driver_if #(.NUM_DIGITS(ND_A)) bus_a ();
    display_shift_driver_if #(.NUM_DIGITS(ND_B)) bus_b ();

    display_shift_driver #(
        .NUM_DIGITS(ND_A),
        .CLK_DIV   (CD_A),
        .ACTIVE_LOW(AL_A)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    display_shift_driver #(
        .NUM_DIGITS(ND_B),
        .CLK_DIV   (CD_B),
        .ACTIVE_LOW(AL_B)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int         bytes_a = 0;
    int         bytes_b = 0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Expected segment byte for digit idx; a digit is blank when it and every
    // digit above it are zero (never digit 0).
    function automatic logic [7:0] exp_byte(input logic [23:0] bcd, input logic [5:0] dp,
                                            input int idx, input bit active_low);
        logic [7:0]  w;
`ifdef LEADING_ZERO_BLANK_EN
        logic [23:0] upper;
`endif
        w = {dp[idx], glyph_of(bcd[4*idx +: 4])};
`ifdef LEADING_ZERO_BLANK_EN
        upper = bcd >> (4 * idx);
        if ((idx != 0) && (upper == 24'd0)) w[6:0] = 7'h00;
`endif
        if (active_low) w = ~w;
        return w;
    endfunction

    // Reassemble bytes on shift-clock rising edges, sampled at clk negedges.
    logic [7:0] shreg_a;
    int         nbits_a = 0;
    logic       prev_cl_a = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            nbits_a   = 0;
            prev_cl_a = 1'b0;
        end else begin
            if (bus_a.clk_logica && !prev_cl_a) begin
                shreg_a = {shreg_a[6:0], bus_a.data_out};
                nbits_a++;
                if (nbits_a == 8) begin
                    nbits_a = 0;
                    bytes_a++;
                    checkOutput("a_sb_has_entry", 32'(sb_a.size() != 0), 32'd1);
                    if (sb_a.size() != 0)
                        checkOutput("a_byte", {24'd0, shreg_a}, {24'd0, sb_a.pop_front()});
                end
            end
            prev_cl_a = bus_a.clk_logica;
        end
    end

    logic [7:0] shreg_b;
    int         nbits_b = 0;
    logic       prev_cl_b = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            nbits_b   = 0;
            prev_cl_b = 1'b0;
        end else begin
            if (bus_b.clk_logica && !prev_cl_b) begin
                shreg_b = {shreg_b[6:0], bus_b.data_out};
                nbits_b++;
                if (nbits_b == 8) begin
                    nbits_b = 0;
                    bytes_b++;
                    checkOutput("b_sb_has_entry", 32'(sb_b.size() != 0), 32'd1);
                    if (sb_b.size() != 0)
                        checkOutput("b_byte", {24'd0, shreg_b}, {24'd0, sb_b.pop_front()});
                end
            end
            prev_cl_b = bus_b.clk_logica;
        end
    end

    // Requests one frame on instance A, queues its bytes, then scrambles the
    // inputs so the frame must come from the captured copy.
    task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dp);
        int waited = 0;
        while (!bus_a.ready && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("a_idle_before_load", 32'(bus_a.ready), 32'd1);
        bus_a.bcd_in = bcd;
        bus_a.dp_in  = dp;
        bus_a.load   = 1'b1;
        for (int i = ND_A - 1; i >= 0; i--)
            sb_a.push_back(exp_byte({8'd0, bcd}, {2'b00, dp}, i, AL_A));
        @(posedge clk); #1;
        bus_a.load   = 1'b0;
        bus_a.bcd_in = 16'hDEAD;
        bus_a.dp_in  = 4'b1010;
    endtask

    // Counts cycles after the accept edge until ready returns; optionally
    // pulses a competing load at cycle pulse_at.
    task automatic wait_frame(input int pulse_at, output int dr_first,
                              output int dr_len, output int rdy_at);
        dr_first = -1;
        dr_len   = 0;
        rdy_at   = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (k == pulse_at) begin
                bus_a.load   = 1'b1;
                bus_a.bcd_in = 16'h5555;
            end else begin
                bus_a.load = 1'b0;
            end
            if (bus_a.ready) begin
                rdy_at = k;
                break;
            end
            if (bus_a.data_ready) begin
                if (dr_first < 0) dr_first = k;
                dr_len++;
            end
        end
        bus_a.load = 1'b0;
    endtask

    task automatic check_timing(input string tag, input int dr_first, input int dr_len,
                                input int rdy_at);
        checkOutput({tag, "_latch_start"}, dr_first, 16 * ND_A * CD_A);
        checkOutput({tag, "_latch_len"},   dr_len,   CD_A);
        checkOutput({tag, "_ready_at"},    rdy_at,   (16 * ND_A + 1) * CD_A);
    endtask

    // Instance B with load held high: frames must follow back to back, each
    // busy for (16*N+1)*CLK_DIV cycles with one latch cycle and a shift clock
    // toggling every cycle while shifting.
    task automatic run_back_to_back();
        int          busy;
        int          drc;
        int          terr;
        logic        prev_cl;
        bit          shifting;
        logic [23:0] bcd;
        logic [5:0]  dp;
        bcd = 24'h009A0F;
        dp  = 6'b000100;
        @(negedge clk);
        checkOutput("b_idle_start", 32'(bus_b.ready), 32'd1);
        bus_b.bcd_in = bcd;
        bus_b.dp_in  = dp;
        bus_b.load   = 1'b1;
        for (int i = ND_B - 1; i >= 0; i--) sb_b.push_back(exp_byte(bcd, dp, i, AL_B));
        for (int f = 0; f < 3; f++) begin
            @(posedge clk); #1;
            bcd = 24'($urandom);
            dp  = 6'($urandom);
            bus_b.bcd_in = bcd;
            bus_b.dp_in  = dp;
            busy = 0; drc = 0; terr = 0; shifting = 0; prev_cl = 1'b0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (bus_b.ready) break;
                busy++;
                if (bus_b.data_ready) begin
                    drc++;
                end else begin
                    if (shifting && (bus_b.clk_logica == prev_cl)) terr++;
                    shifting = 1'b1;
                    prev_cl  = bus_b.clk_logica;
                end
            end
            checkOutput("b_busy_len",   busy, (16 * ND_B + 1) * CD_B);
            checkOutput("b_latch_len",  drc,  CD_B);
            checkOutput("b_toggle_err", terr, 0);
            if (f < 2) begin
                for (int i = ND_B - 1; i >= 0; i--) sb_b.push_back(exp_byte(bcd, dp, i, AL_B));
            end else begin
                bus_b.load = 1'b0;
            end
        end
        repeat (20) @(negedge clk);
        checkOutput("b_byte_count", bytes_b, 3 * ND_B);
        checkOutput("b_sb_empty",   sb_b.size(), 0);
        checkOutput("b_idle_end",   32'(bus_b.ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dr_first;
        int dr_len;
        int rdy_at;
        int b0;

        rst          = 1'b1;
        bus_a.load   = 1'b0;
        bus_a.bcd_in = '0;
        bus_a.dp_in  = '0;
        bus_b.load   = 1'b0;
        bus_b.bcd_in = '0;
        bus_b.dp_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready",      32'(bus_a.ready),      32'd1);
        checkOutput("rst_data_out",   32'(bus_a.data_out),   32'd0);
        checkOutput("rst_clk_logica", 32'(bus_a.clk_logica), 32'd0);
        checkOutput("rst_data_ready", 32'(bus_a.data_ready), 32'd0);
        checkOutput("rst_ready_b",    32'(bus_b.ready),      32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] all-ones frame");
        applyStimulus(16'h1111, 4'b0000);
        wait_frame(-1, dr_first, dr_len, rdy_at);
        check_timing("t1", dr_first, dr_len, rdy_at);
        checkOutput("t1_bytes", bytes_a, 4);

        $display("[TB] mixed glyphs with decimal point");
        applyStimulus(16'h9A0F, 4'b0100);
        wait_frame(-1, dr_first, dr_len, rdy_at);
        checkOutput("t2_sb_empty", sb_a.size(), 0);

        $display("[TB] load while busy");
        b0 = bytes_a;
        applyStimulus(16'h1234, 4'b1001);
        wait_frame(20, dr_first, dr_len, rdy_at);
        check_timing("t3", dr_first, dr_len, rdy_at);
        repeat (40) @(negedge clk);
        checkOutput("t3_frame_bytes", bytes_a - b0, 4);
        checkOutput("t3_still_idle",  32'(bus_a.ready), 32'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(16'h8888, 4'b1111);
        for (int k = 0; k <= 50; k++) @(negedge clk);
        checkOutput("t4_pre_clk_logica", 32'(bus_a.clk_logica), 32'd1);
        checkOutput("t4_pre_data_out",   32'(bus_a.data_out),   32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("t4_data_out",   32'(bus_a.data_out),   32'd0);
        checkOutput("t4_clk_logica", 32'(bus_a.clk_logica), 32'd0);
        checkOutput("t4_data_ready", 32'(bus_a.data_ready), 32'd0);
        checkOutput("t4_ready",      32'(bus_a.ready),      32'd1);
        @(negedge clk); #1;
        rst = 1'b0;
        sb_a.delete();
        @(posedge clk); #1;
        applyStimulus(16'h4567, 4'b0010);
        wait_frame(-1, dr_first, dr_len, rdy_at);
        check_timing("t4_after", dr_first, dr_len, rdy_at);
        checkOutput("t4_sb_empty", sb_a.size(), 0);

        $display("[TB] leading zeros");
        applyStimulus(16'h0012, 4'b0000);
        wait_frame(-1, dr_first, dr_len, rdy_at);
        check_timing("t5", dr_first, dr_len, rdy_at);
        applyStimulus(16'h0000, 4'b0000);
        wait_frame(-1, dr_first, dr_len, rdy_at);
        applyStimulus(16'h0300, 4'b1000);
        wait_frame(-1, dr_first, dr_len, rdy_at);
        checkOutput("t5_sb_empty", sb_a.size(), 0);

        $display("[TB] back-to-back frames, CLK_DIV=1");
        run_back_to_back();

        checkOutput("final_sb_a_empty", sb_a.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
